// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the MMIO bus router and its address decoder.
//   - state_e: router transaction state machine encoding
//   - default CPU memory map (SDRAM, flash, VRAM32, VRAM8) as flattened
//     base/limit vectors, region i at slice i
//   - clog2: ceiling log2 usable in parameter expressions
package mmio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ERR,
    DONE
  } state_e;

  localparam int unsigned MAP_ADDR_W = 27;

  localparam logic [MAP_ADDR_W-1:0] SDRAM_BASE   = 27'h000000;
  localparam logic [MAP_ADDR_W-1:0] SDRAM_LIMIT  = 27'h800000;
  localparam logic [MAP_ADDR_W-1:0] FLASH_BASE   = 27'h800000;
  localparam logic [MAP_ADDR_W-1:0] FLASH_LIMIT  = 27'hC00000;
  localparam logic [MAP_ADDR_W-1:0] VRAM32_BASE  = 27'hC00000;
  localparam logic [MAP_ADDR_W-1:0] VRAM32_LIMIT = 27'hC00420;
  localparam logic [MAP_ADDR_W-1:0] VRAM8_BASE   = 27'hC00420;
  localparam logic [MAP_ADDR_W-1:0] VRAM8_LIMIT  = 27'hC02422;

  // Slave 0 = SDRAM, 1 = flash, 2 = VRAM32, 3 = VRAM8.
  localparam logic [4*MAP_ADDR_W-1:0] DEFAULT_REGION_BASE =
    {VRAM8_BASE, VRAM32_BASE, FLASH_BASE, SDRAM_BASE};
  localparam logic [4*MAP_ADDR_W-1:0] DEFAULT_REGION_LIMIT =
    {VRAM8_LIMIT, VRAM32_LIMIT, FLASH_LIMIT, SDRAM_LIMIT};

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mmio_region_decode.sv
// mmio_region_decode: combinational priority address decoder.
//   Region i covers REGION_BASE[i] <= addr_i < REGION_LIMIT[i]; the lowest
//   hitting index wins, and a region with base == limit never hits.
// Ports:
//   addr_i   in   ADDR_W  address to decode
//   hit_o    out  1       some region contains addr_i
//   idx_o    out  IDX_W   index of the winning region (0 when no hit)
//   offset_o out  ADDR_W  addr_i minus the winning region's base (0 when no hit)
module mmio_region_decode
  import mmio_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned ADDR_W      = 27,
  parameter int unsigned IDX_W       = (NUM_REGIONS > 1) ? clog2(NUM_REGIONS) : 1,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = '0,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic [ADDR_W-1:0] offset_o
);

  logic [ADDR_W-1:0]      base  [NUM_REGIONS];
  logic [ADDR_W-1:0]      limit [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] in_region;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    assign base[g]      = REGION_BASE[g*ADDR_W +: ADDR_W];
    assign limit[g]     = REGION_LIMIT[g*ADDR_W +: ADDR_W];
    assign in_region[g] = (addr_i >= base[g]) && (addr_i < limit[g]);
  end

  // Ascending scan that keeps only the first hit gives lowest-index priority.
  always_comb begin
    hit_o    = 1'b0;
    idx_o    = '0;
    offset_o = '0;
    for (int unsigned j = 0; j < NUM_REGIONS; j++) begin
      if (in_region[j] && !hit_o) begin
        hit_o    = 1'b1;
        idx_o    = IDX_W'(j);
        offset_o = addr_i - base[j];
      end
    end
  end

endmodule

// File: rtl/mmio_bus_router.sv
// mmio_bus_router: routes one CPU request to one of NUM_SLAVES address
// regions, waits for that slave's done handshake (with optional timeout),
// and returns registered read data plus an error flag.
// Ports:
//   clk      in   1                  system clock, rising edge
//   reset    in   1                  asynchronous active-low reset
//   address  in   ADDR_W             CPU address
//   data     in   DATA_W             CPU write data
//   we       in   1                  CPU write enable
//   start    in   1                  CPU request, held until busy is seen low
//   busy     out  1                  transaction in progress
//   q        out  DATA_W             registered read data
//   err      out  1                  last transaction unmapped or timed out
//   s_sel    out  NUM_SLAVES         one-hot slave select for the transaction
//   s_addr   out  ADDR_W             address relative to the region base
//   s_d      out  DATA_W             latched write data
//   s_we     out  1                  latched write enable
//   s_start  out  1                  single-cycle start pulse to the slave
//   s_done   in   NUM_SLAVES         per-slave completion
//   s_q      in   NUM_SLAVES*DATA_W  per-slave read data, slave i at slice i
module mmio_bus_router
  import mmio_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 27,
  parameter int unsigned DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_BASE  = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_LIMIT = '0,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            address,
  input  logic [DATA_W-1:0]            data,
  input  logic                         we,
  input  logic                         start,
  output logic                         busy,
  output logic [DATA_W-1:0]            q,
  output logic                         err,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_d,
  output logic                         s_we,
  output logic                         s_start,
  input  logic [NUM_SLAVES-1:0]        s_done,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_q
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? clog2(NUM_SLAVES) : 1;
  // Abort fires on equality, so the counter never needs to hold TIMEOUT+1.
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;

  state_e              state_q, state_d;
  logic                busy_q;
  logic                err_q;
  logic [DATA_W-1:0]   q_q;
  logic [NUM_SLAVES-1:0] s_sel_q;
  logic [ADDR_W-1:0]   s_addr_q;
  logic [DATA_W-1:0]   s_d_q;
  logic                s_we_q;
  logic [IDX_W-1:0]    sel_idx_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic [ADDR_W-1:0]   dec_offset;
  logic [DATA_W-1:0]   slave_q [NUM_SLAVES];
  logic                sel_done;
  logic                timeout_hit;

  mmio_region_decode #(
    .NUM_REGIONS  (NUM_SLAVES),
    .ADDR_W       (ADDR_W),
    .IDX_W        (IDX_W),
    .REGION_BASE  (REGION_BASE),
    .REGION_LIMIT (REGION_LIMIT)
  ) u_decode (
    .addr_i   (address),
    .hit_o    (dec_hit),
    .idx_o    (dec_idx),
    .offset_o (dec_offset)
  );

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slave_q
    assign slave_q[g] = s_q[g*DATA_W +: DATA_W];
  end

  // Only the latched slave's done is observed; others are ignored.
  assign sel_done    = s_done[sel_idx_q];
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = dec_hit ? ISSUE : ERR;
      ISSUE:   state_d = WAIT;
      WAIT:    if (sel_done || timeout_hit) state_d = DONE;
      ERR:     state_d = DONE;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    s_start = (state_q == ISSUE);
  end

  // Transaction datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      q_q       <= '0;
      s_sel_q   <= '0;
      s_addr_q  <= '0;
      s_d_q     <= '0;
      s_we_q    <= 1'b0;
      sel_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            err_q  <= 1'b0;
            if (dec_hit) begin
              s_sel_q   <= NUM_SLAVES'(1) << dec_idx;
              s_addr_q  <= dec_offset;
              s_d_q     <= data;
              s_we_q    <= we;
              sel_idx_q <= dec_idx;
            end else begin
              q_q <= '0;
            end
          end
        end
        ISSUE: cnt_q <= '0;
        WAIT: begin
          if (sel_done) begin
            q_q <= slave_q[sel_idx_q];
          end else if (timeout_hit) begin
            q_q   <= '0;
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ERR: err_q <= 1'b1;
        DONE: begin
          busy_q  <= 1'b0;
          s_sel_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy   = busy_q;
  assign err    = err_q;
  assign q      = q_q;
  assign s_sel  = s_sel_q;
  assign s_addr = s_addr_q;
  assign s_d    = s_d_q;
  assign s_we   = s_we_q;

endmodule
